// File: rtl/uart_fifo_core.sv
// uart_fifo_core: 16-entry synchronous FIFO shared by the UART receive and
// transmit paths. The head entry is visible combinationally on data_out.
// The receive instance stores {data[7:0], break, parity_err, framing_err},
// and error_bit reports whether any valid entry has a status bit set.
module uart_fifo_core #(
   parameter int FIFO_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int FIFO_POINTER_W = 4,
   parameter int FIFO_COUNTER_W = 5
) (
   input  logic                      clk,
   input  logic                      wb_rst_i,
   input  logic [FIFO_WIDTH-1:0]     data_in,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      fifo_reset,
   input  logic                      reset_status,
   output logic [FIFO_WIDTH-1:0]     data_out,
   output logic [FIFO_COUNTER_W-1:0] count,
   output logic                      overrun,
   output logic                      error_bit
);

   localparam logic [FIFO_COUNTER_W-1:0] FULL_COUNT = FIFO_COUNTER_W'(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0]     storage [FIFO_DEPTH];
   logic [FIFO_POINTER_W-1:0] wr_ptr;
   logic [FIFO_POINTER_W-1:0] rd_ptr;
   logic                      full;
   logic                      empty;
   logic                      do_write;
   logic                      do_read;
   logic                      lost_push;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // A push is accepted when there is room, or when a pop frees the head in
   // the same cycle. A push together with a pop on an empty FIFO is a plain
   // push, because there is nothing to pop.
   assign do_write  = push && !fifo_reset && (!full || pop);
   assign do_read   = pop  && !fifo_reset && !empty;
   assign lost_push = push && !pop && full && !fifo_reset;

   assign data_out = storage[rd_ptr];

   // Pointer, occupancy and overrun bookkeeping; a flush has top priority.
   // NOTE: sequential state uses non-blocking assignments, so every register
   // in the block samples the pre-edge values and the update order does not matter.
   always_ff @(posedge clk or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else if (fifo_reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + FIFO_POINTER_W'(1);
         if (do_read)  rd_ptr <= rd_ptr + FIFO_POINTER_W'(1);
         if (do_write && !do_read)
            count <= count + FIFO_COUNTER_W'(1);
         else if (do_read && !do_write)
            count <= count - FIFO_COUNTER_W'(1);
         if (lost_push)
            overrun <= 1'b1;
         else if (reset_status)
            overrun <= 1'b0;
      end
   end

   // Entry storage. A flush leaves the contents in place; it only invalidates them.
   // NOTE: the storage array is cleared on reset so that data_out and error_bit
   // come up at known zero values. Without this, both would read uninitialised
   // storage after reset.
   always_ff @(posedge clk or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) storage[i] <= '0;
      end else if (do_write) begin
         storage[wr_ptr] <= data_in;
      end
   end

   if (FIFO_WIDTH >= 3) begin : g_err
      logic [2:0]                err_acc;
      logic [FIFO_POINTER_W-1:0] offset;

      // OR the status bits of the entries that are valid: slot i is valid
      // when its distance from the read pointer is below the occupancy.
      // NOTE: every variable gets a default before the loop, so that no
      // path leaves a variable unassigned and no latch is inferred.
      always_comb begin
         err_acc = '0;
         offset  = '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = FIFO_POINTER_W'(i) - rd_ptr;
            if (FIFO_COUNTER_W'(offset) < count) err_acc = err_acc | storage[i][2:0];
         end
         error_bit = |err_acc;
      end
   end else begin : g_no_err
      assign error_bit = 1'b0;
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed and randomized checks of uart_fifo_core in the
// 11-bit receive configuration. A queue-based reference model provides every
// expected value.
module tb_uart_fifo_core;

   localparam int W = 11;

   logic          clk = 1'b0;
   logic          wb_rst_i;
   logic [W-1:0]  data_in;
   logic          push;
   logic          pop;
   logic          fifo_reset;
   logic          reset_status;
   logic [W-1:0]  data_out;
   logic [4:0]    count;
   logic          overrun;
   logic          error_bit;

   int            n_vec  = 0;
   int            n_fail = 0;

   // Reference model: an ordered queue of the valid entries plus the overrun flag.
   logic [W-1:0]  q[$];
   logic          m_ovr = 1'b0;

   uart_fifo_core #(
      .FIFO_WIDTH     (W),
      .FIFO_DEPTH     (16),
      .FIFO_POINTER_W (4),
      .FIFO_COUNTER_W (5)
   ) dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .data_in      (data_in),
      .push         (push),
      .pop          (pop),
      .fifo_reset   (fifo_reset),
      .reset_status (reset_status),
      .data_out     (data_out),
      .count        (count),
      .overrun      (overrun),
      .error_bit    (error_bit)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err();
      logic e = 1'b0;
      foreach (q[i]) e = e | (|q[i][2:0]);
      return e;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".count"},     32'(count),     32'(q.size()));
      check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
      check({tag, ".error_bit"}, 32'(error_bit), 32'(model_err()));
      if (q.size() > 0) check({tag, ".data_out"}, 32'(data_out), 32'(q[0]));
   endtask

   task automatic model_update(input logic p, input logic po, input logic [W-1:0] d,
                               input logic fr, input logic rs);
      logic lost = 1'b0;
      if (fr) begin
         q.delete();
         m_ovr = 1'b0;
      end else begin
         if (p && po && q.size() > 0) begin
            void'(q.pop_front());
            q.push_back(d);
         end else if (p) begin
            if (q.size() < 16) q.push_back(d);
            else lost = 1'b1;
         end else if (po && q.size() > 0) begin
            void'(q.pop_front());
         end
         if (lost) m_ovr = 1'b1;
         else if (rs) m_ovr = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then check #1 later.
   task automatic cycle(input string tag, input logic p, input logic po, input logic [W-1:0] d,
                        input logic fr, input logic rs);
      push = p; pop = po; data_in = d; fifo_reset = fr; reset_status = rs;
      @(posedge clk);
      model_update(p, po, d, fr, rs);
      #1;
      push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0;
      check_all(tag);
   endtask

   task automatic do_push(input string tag, input logic [W-1:0] d);
      cycle(tag, 1'b1, 1'b0, d, 1'b0, 1'b0);
   endtask

   task automatic do_pop(input string tag);
      cycle(tag, 1'b0, 1'b1, '0, 1'b0, 1'b0);
   endtask

   // Directed steps, followed by wrap-around and randomized phases.
   initial begin
      logic [W-1:0] first;
      logic [W-1:0] tail;

      wb_rst_i = 1'b0; data_in = '0; push = 1'b0; pop = 1'b0;
      fifo_reset = 1'b0; reset_status = 1'b0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold.count",    32'(count),     32'd0);
      check("rst_hold.data_out", 32'(data_out),  32'd0);
      wb_rst_i = 1'b1;
      @(posedge clk);
      #1;
      check("rst.count",     32'(count),     32'd0);
      check("rst.overrun",   32'(overrun),   32'd0);
      check("rst.error_bit", 32'(error_bit), 32'd0);
      check("rst.data_out",  32'(data_out),  32'd0);

      // Ordering
      do_push("ord_push", 11'h008);
      do_push("ord_push", 11'h010);
      do_push("ord_push", 11'h018);
      check("ord.head0", 32'(data_out), 32'h008);
      do_pop("ord_pop");
      check("ord.head1", 32'(data_out), 32'h010);
      do_pop("ord_pop");
      check("ord.head2", 32'(data_out), 32'h018);
      do_pop("ord_pop");
      check("ord.empty", 32'(count), 32'd0);

      // Full and overrun
      for (int i = 0; i < 16; i++) do_push("fill", W'($urandom));
      first = q[0];
      do_push("ovf_push", 11'h7F8);
      check("ovf.count",   32'(count),    32'd16);
      check("ovf.overrun", 32'(overrun),  32'd1);
      check("ovf.head",    32'(data_out), 32'(first));
      cycle("rst_status", 1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("rs.overrun", 32'(overrun), 32'd0);
      check("rs.count",   32'(count),   32'd16);

      // Overflow in the same cycle as reset_status: set wins
      cycle("ovf_and_rs", 1'b1, 1'b0, 11'h123, 1'b0, 1'b1);
      check("ovf_rs.overrun", 32'(overrun), 32'd1);
      cycle("rst_status2", 1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Simultaneous push/pop on a full FIFO
      tail = 11'h5A8;
      cycle("full_pp", 1'b1, 1'b1, tail, 1'b0, 1'b0);
      check("full_pp.count",   32'(count),   32'd16);
      check("full_pp.overrun", 32'(overrun), 32'd0);
      for (int i = 0; i < 15; i++) do_pop("drain15");
      check("full_pp.tail_head", 32'(data_out), 32'(tail));
      do_pop("drain_last");

      // Simultaneous push/pop on an empty FIFO
      cycle("empty_pp", 1'b1, 1'b1, 11'h2B0, 1'b0, 1'b0);
      check("empty_pp.count", 32'(count),    32'd1);
      check("empty_pp.head",  32'(data_out), 32'h2B0);
      do_pop("empty_pp_pop");

      // Errors
      do_push("err_push", 11'h041);
      do_push("err_push", 11'h040);
      check("err.set", 32'(error_bit), 32'd1);
      do_pop("err_pop");
      check("err.clear", 32'(error_bit), 32'd0);
      do_pop("err_pop2");

      // Flush mid-operation with 5 entries and overrun set
      for (int i = 0; i < 16; i++) do_push("fl_fill", W'($urandom) | 11'h004);
      do_push("fl_ovf", 11'h3F8);
      for (int i = 0; i < 11; i++) do_pop("fl_pop");
      check("fl.pre_count",   32'(count),   32'd5);
      check("fl.pre_overrun", 32'(overrun), 32'd1);
      cycle("flush_push", 1'b1, 1'b0, 11'h155, 1'b1, 1'b0);
      check("fl.count",   32'(count),     32'd0);
      check("fl.overrun", 32'(overrun),   32'd0);
      check("fl.err",     32'(error_bit), 32'd0);
      do_pop("fl_empty_pop");
      check("fl.underflow", 32'(count), 32'd0);
      do_push("fl_after", 11'h0A8);
      check("fl.after_head", 32'(data_out), 32'h0A8);
      do_pop("fl_after_pop");

      // Wrap-around: 40 interleaved push/pop pairs
      for (int i = 0; i < 40; i++) begin
         do_push("wrap_push", W'($urandom));
         if (i % 3 == 0) do_push("wrap_push2", W'($urandom));
         do_pop("wrap_pop");
      end

      // Randomized mix, biased toward push so the FIFO visits full
      for (int i = 0; i < 400; i++) begin
         cycle("rand",
               ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 9) < 4),
               W'($urandom),
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
